// File: rtl/cookie_grid_if.sv
// Interface for the cookie_grid interface signals: load chain, run control, status and display chain.
// The master drives the controls and the slave (the grid) drives the status and serial outputs.
interface cookie_grid_if #(
  parameter int GEN_W = 8
);
  logic             en;
  logic             shift_en;
  logic             input_bit;
  logic             output_bit;
  logic             start;
  logic [GEN_W-1:0] gens;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_count;
  logic             stable;
  logic             extinct;
  logic             display;
  logic             disp_shift_en;
  logic             display_shift_in;
  logic             display_shift_out;

  modport master (
    output en, shift_en, input_bit, start, gens, display, disp_shift_en, display_shift_in,
    input  output_bit, busy, done, gen_count, stable, extinct, display_shift_out
  );

  modport slave (
    input  en, shift_en, input_bit, start, gens, display, disp_shift_en, display_shift_in,
    output output_bit, busy, done, gen_count, stable, extinct, display_shift_out
  );
endinterface

// File: rtl/cookie_grid.sv
// Serially loaded Game-of-Life (B3/S23) grid with a bounded multi-generation run engine
// and an independent snapshot/shift display chain.
module cookie_grid #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int GEN_W = 8,
  parameter int WRAP  = 1
) (
  input logic          clk,
  input logic          rst,
  cookie_grid_if.slave bus
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     cells_q, cells_d;
  logic [N-1:0]     life_next;
  logic [N-1:0]     disp_q, disp_d;
  logic [GEN_W-1:0] target_q, target_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stable_q, stable_d;
  logic             extinct_q, extinct_d;

  // Off-grid coordinates either wrap around (torus) or read as dead.
  function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
    int rr;
    int cc;
    logic alive;
    alive = 1'b0;
    if (WRAP != 0) begin
      rr    = (r + ROWS) % ROWS;
      cc    = (c + COLS) % COLS;
      alive = g[IDX_W'(rr * COLS + cc)];
    end else if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
      alive = g[IDX_W'(r * COLS + c)];
    end
    return alive;
  endfunction

  function automatic logic [3:0] nbr_count(input logic [N-1:0] g, input int r, input int c);
    logic [3:0] n;
    n = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
          n = n + {3'b000, cell_at(g, r + dr, c + dc)};
        end
      end
    end
    return n;
  endfunction

  function automatic logic b3s23(input logic alive, input logic [3:0] n);
    return (n == 4'd3) || (alive && n == 4'd2);
  endfunction

  // Every cell's successor is computed from the same current grid, so the whole
  // generation is applied in one step.
  always_comb begin
    life_next = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        life_next[IDX_W'(r * COLS + c)] =
          b3s23(cells_q[IDX_W'(r * COLS + c)], nbr_count(cells_q, r, c));
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold value before any branch, so no path can infer a latch.
    state_d   = state_q;
    cells_d   = cells_q;
    target_d  = target_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;

    if (bus.en) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            stable_d = 1'b0;
            if (bus.gens != '0) begin
              target_d  = bus.gens;
              gen_d     = '0;
              extinct_d = 1'b0;
              state_d   = S_RUN;
            end else begin
              extinct_d = (cells_q == '0);
              state_d   = S_DONE;
            end
          end else if (bus.shift_en) begin
            cells_d = {cells_q[N-2:0], bus.input_bit};
          end
        end

        S_RUN: begin
          if (life_next == cells_q) begin
            stable_d  = 1'b1;
            extinct_d = (cells_q == '0);
            state_d   = S_DONE;
          end else begin
            cells_d = life_next;
            gen_d   = gen_q + GEN_W'(1);
            if (gen_d == target_q) begin
              extinct_d = (life_next == '0);
              state_d   = S_DONE;
            end
          end
        end

        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Display chain: a snapshot wins over shifting; it never looks at the FSM.
  always_comb begin
    disp_d = disp_q;
    if (bus.en) begin
      if (bus.display) begin
        disp_d = cells_q;
      end else if (bus.disp_shift_en) begin
        disp_d = {disp_q[N-2:0], bus.display_shift_in};
      end
    end
  end

  // NOTE: the grid and display chain are plain flops rather than a RAM, so they take the async clear like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cells_q   <= '0;
      disp_q    <= '0;
      target_q  <= '0;
      gen_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every register sample the pre-edge values.
      state_q   <= state_d;
      cells_q   <= cells_d;
      disp_q    <= disp_d;
      target_q  <= target_d;
      gen_q     <= gen_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
    end
  end

  assign bus.output_bit        = cells_q[N-1];
  assign bus.display_shift_out = disp_q[N-1];
  assign bus.busy              = (state_q == S_RUN);
  assign bus.done              = (state_q == S_DONE);
  assign bus.gen_count         = gen_q;
  assign bus.stable            = stable_q;
  assign bus.extinct           = extinct_q;

endmodule

// File: tb/tb_cookie_grid.sv
// Randomised scoreboard bench for cookie_grid: a neighbour-list Life model predicts each run,
// and a monitor compares the prediction whenever the DUT raises done.
module tb_cookie_grid;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int N     = ROWS * COLS;
  localparam int GEN_W = 8;

  typedef struct {
    logic [GEN_W-1:0] gen_count;
    bit               stable;
    bit               extinct;
    int               cycles;
    int               done_edge;
  } exp_t;

  logic clk;
  logic rst;
  cookie_grid_if #(.GEN_W(GEN_W)) ifc ();

  cookie_grid #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .WRAP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               checks   = 0;
  int               failures = 0;
  int               en_edges = 0;
  exp_t             sb[$];
  logic [N-1:0]     m_grid;
  logic [N-1:0]     m_gen1;
  logic [GEN_W-1:0] m_gen_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Enabled clock edges since time zero; lets the monitor check done latency independent of en gaps.
  always @(posedge clk) begin
    if (!rst && ifc.en) en_edges <= en_edges + 1;
  end

  // Monitor: a DONE cycle that will be consumed by the next edge pops one prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ifc.en && ifc.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(ifc.done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("done_gen_count", 64'(ifc.gen_count), 64'(e.gen_count));
        check("done_stable",    64'(ifc.stable),    64'(e.stable));
        check("done_extinct",   64'(ifc.extinct),   64'(e.extinct));
        check("done_busy",      64'(ifc.busy),      64'd0);
        check("done_latency",   64'(en_edges),      64'(e.done_edge));
      end
    end
  end

  // Two cells are neighbours when their toroidal distance is at most one on both axes.
  function automatic bit tor_near(input int a, input int b, input int m);
    int d;
    d = (a > b) ? a - b : b - a;
    return (d <= 1) || (m - d <= 1);
  endfunction

  function automatic logic [N-1:0] life_step(input logic [N-1:0] g);
    int lr[N];
    int lc[N];
    int live;
    int n;
    logic [N-1:0] nx;
    live = 0;
    nx   = '0;
    for (int i = 0; i < N; i++) begin
      lr[i] = 0;
      lc[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        lr[live] = i / COLS;
        lc[live] = i % COLS;
        live++;
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int j = 0; j < live; j++) begin
          if (tor_near(r, lr[j], ROWS) && tor_near(c, lc[j], COLS) && !(r == lr[j] && c == lc[j]))
            n++;
        end
        nx[r * COLS + c] = (n == 3) || (g[r * COLS + c] && n == 2);
      end
    end
    return nx;
  endfunction

  task automatic model_run(input logic [N-1:0] g, input int gens_v, output exp_t e,
                           output logic [N-1:0] fin, output logic [N-1:0] g1);
    logic [N-1:0] cur;
    logic [N-1:0] nx;
    int k;
    cur         = g;
    g1          = g;
    k           = 0;
    e.stable    = 1'b0;
    e.extinct   = (g == '0);
    e.gen_count = m_gen_count;
    e.cycles    = 0;
    e.done_edge = 0;
    if (gens_v != 0) begin
      while (1) begin
        nx = life_step(cur);
        if (nx == cur) begin
          e.stable  = 1'b1;
          e.extinct = (cur == '0);
          e.cycles  = k + 1;
          break;
        end
        cur = nx;
        k++;
        if (k == 1) g1 = cur;
        if (k == gens_v) begin
          e.extinct = (cur == '0);
          e.cycles  = k;
          break;
        end
      end
      e.gen_count = GEN_W'(k);
    end
    fin = cur;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cell[i] ends up holding g[i]: the MSB goes in first and travels furthest.
  task automatic load_grid(input logic [N-1:0] g);
    for (int k = N - 1; k >= 0; k--) begin
      ifc.shift_en  = 1'b1;
      ifc.input_bit = g[k];
      step();
    end
    ifc.shift_en  = 1'b0;
    ifc.input_bit = 1'b0;
    m_grid        = g;
  endtask

  task automatic start_run(input int gens_v, input bit shift_too);
    exp_t e;
    logic [N-1:0] fin;
    logic [N-1:0] g1;
    model_run(m_grid, gens_v, e, fin, g1);
    e.done_edge = en_edges + 1 + e.cycles;
    sb.push_back(e);
    m_grid        = fin;
    m_gen1        = g1;
    m_gen_count   = e.gen_count;
    ifc.start     = 1'b1;
    ifc.gens      = GEN_W'(gens_v);
    ifc.shift_en  = shift_too;
    ifc.input_bit = 1'b1;
    step();
    ifc.start     = 1'b0;
    ifc.shift_en  = 1'b0;
    ifc.input_bit = 1'b0;
  endtask

  // While running, optionally toggle start/shift/gens, all of which the RUN state must ignore.
  task automatic wait_done(input bit noise);
    int n;
    n = 0;
    while (!ifc.done && n < 300) begin
      if (noise) begin
        ifc.start     = 1'($urandom);
        ifc.shift_en  = 1'($urandom);
        ifc.input_bit = 1'($urandom);
        ifc.gens      = GEN_W'($urandom);
      end
      step();
      n++;
    end
    ifc.start     = 1'b0;
    ifc.shift_en  = 1'b0;
    ifc.input_bit = 1'b0;
    check("done_seen", 64'(ifc.done), 64'd1);
    step();
  endtask

  // Read the display chain MSB-first: disp[N-1] is visible before the first shift.
  task automatic read_disp(input bit snap, output logic [N-1:0] v);
    if (snap) begin
      ifc.display = 1'b1;
      step();
      ifc.display = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      v[N - 1 - k]         = ifc.display_shift_out;
      ifc.disp_shift_en    = 1'b1;
      ifc.display_shift_in = 1'b0;
      step();
    end
    ifc.disp_shift_en = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] v;
    int n;
    rst                  = 1'b1;
    ifc.en               = 1'b1;
    ifc.shift_en         = 1'b0;
    ifc.input_bit        = 1'b0;
    ifc.start            = 1'b0;
    ifc.gens             = '0;
    ifc.display          = 1'b0;
    ifc.disp_shift_en    = 1'b0;
    ifc.display_shift_in = 1'b0;
    m_grid               = '0;
    m_gen1               = '0;
    m_gen_count          = '0;
    step();
    step();
    check("rst_busy",       64'(ifc.busy),              64'd0);
    check("rst_done",       64'(ifc.done),              64'd0);
    check("rst_gen_count",  64'(ifc.gen_count),         64'd0);
    check("rst_stable",     64'(ifc.stable),            64'd0);
    check("rst_extinct",    64'(ifc.extinct),           64'd0);
    check("rst_output_bit", 64'(ifc.output_bit),        64'd0);
    check("rst_disp_out",   64'(ifc.display_shift_out), 64'd0);
    rst = 1'b0;

    // Serial load and shift-out of 0xA5C3.
    load_grid(16'hA5C3);
    for (int k = 0; k < N; k++) begin
      v[N - 1 - k]  = ifc.output_bit;
      ifc.shift_en  = 1'b1;
      ifc.input_bit = 1'b0;
      step();
    end
    ifc.shift_en = 1'b0;
    check("serial_out", 64'(v), 64'h0000_0000_0000_A5C3);
    m_grid = '0;

    // Still life: a block stops on the first RUN cycle.
    load_grid(16'h0660);
    start_run(5, 1'b0);
    wait_done(1'b0);
    read_disp(1'b1, v);
    check("block_grid", 64'(v), 64'(m_grid));
    check("block_grid_spec", 64'(v), 64'h0660);

    // Blinker with a mid-run snapshot and an enable freeze.
    load_grid(16'h0070);
    start_run(4, 1'b0);
    step();
    check("blinker_gen1_count", 64'(ifc.gen_count), 64'd1);
    ifc.display = 1'b1;
    step();
    ifc.display = 1'b0;
    ifc.en      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("frozen_gen_count", 64'(ifc.gen_count), 64'd2);
      check("frozen_busy",      64'(ifc.busy),      64'd1);
    end
    ifc.en = 1'b1;
    wait_done(1'b0);
    read_disp(1'b0, v);
    check("gen1_snapshot",      64'(v), 64'(m_gen1));
    check("gen1_snapshot_spec", 64'(v), 64'h0222);
    read_disp(1'b1, v);
    check("blinker_grid",      64'(v), 64'(m_grid));
    check("blinker_grid_spec", 64'(v), 64'h0070);

    // Lone cell dies, then the dead grid is detected as stable and extinct.
    load_grid(16'h0020);
    start_run(3, 1'b0);
    wait_done(1'b0);
    read_disp(1'b1, v);
    check("lone_grid", 64'(v), 64'(m_grid));

    // Random grids and generation targets, with stimulus noise during the run.
    for (int t = 0; t < 8; t++) begin
      load_grid(N'($urandom));
      start_run(int'($urandom_range(0, 10)), 1'b1);
      wait_done(1'b1);
      read_disp(1'b1, v);
      check("random_grid", 64'(v), 64'(m_grid));
    end

    // Asynchronous reset in the middle of a run.
    load_grid(16'h0070);
    start_run(10, 1'b0);
    n = 0;
    while (ifc.gen_count != GEN_W'(2) && n < 20) begin
      step();
      n++;
    end
    check("reached_gen2", 64'(ifc.gen_count), 64'd2);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("arst_busy",       64'(ifc.busy),              64'd0);
    check("arst_done",       64'(ifc.done),              64'd0);
    check("arst_gen_count",  64'(ifc.gen_count),         64'd0);
    check("arst_stable",     64'(ifc.stable),            64'd0);
    check("arst_extinct",    64'(ifc.extinct),           64'd0);
    check("arst_output_bit", 64'(ifc.output_bit),        64'd0);
    check("arst_disp_out",   64'(ifc.display_shift_out), 64'd0);
    step();
    rst         = 1'b0;
    m_grid      = '0;
    m_gen_count = '0;
    start_run(0, 1'b0);
    wait_done(1'b0);
    check("post_rst_extinct", 64'(ifc.extinct), 64'd1);
    read_disp(1'b1, v);
    check("post_rst_grid", 64'(v), 64'd0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
